// File: rtl/hub75_pkg.sv
// rtl/hub75_pkg.sv - shared types and geometry defaults for the HUB75 frame-memory blocks
// Purpose: fill-engine state type, pixel word type, default panel geometry and
//          a small round-robin index helper shared by the scheduler and arbiter.
// Ports:   none (package).
package hub75_pkg;

   localparam int HUB75_WIDTH     = 64;
   localparam int HUB75_HEIGHT    = 32;
   localparam int HUB75_N         = 2;
   localparam int HUB75_DATA_BITS = 8;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } hub75_fill_state_t;

   typedef struct packed {
      logic [HUB75_DATA_BITS-1:0] r;
      logic [HUB75_DATA_BITS-1:0] g;
      logic [HUB75_DATA_BITS-1:0] b;
   } hub75_pixel_t;

   // Index reached by stepping 'step' places from 'base' in a ring of 'n'.
   function automatic int rr_index(input int base, input int step, input int n);
      return (base + step) % n;
   endfunction

endpackage

// File: rtl/hub75_rr_arbiter.sv
// rtl/hub75_rr_arbiter.sv - combinational round-robin grant with pointer update
// Purpose: picks the first valid requester at or after ptr (mod NUM_REQ).
// Ports:
//   valid    in  NUM_REQ   request vector
//   en       in  1         arbitration enable; no grant when low
//   ptr      in  PTR_BITS  search start index
//   grant    out NUM_REQ   one-hot grant (all zero when nothing granted)
//   next_ptr out PTR_BITS  index after the winner, or ptr when no grant
module hub75_rr_arbiter
   import hub75_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int PTR_BITS = 1
) (
   input  logic [NUM_REQ-1:0]  valid,
   input  logic                en,
   input  logic [PTR_BITS-1:0] ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [PTR_BITS-1:0] next_ptr
);

   logic found;

   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      found    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (en && !found && valid[rr_index(int'(ptr), k, NUM_REQ)]) begin
            grant[rr_index(int'(ptr), k, NUM_REQ)] = 1'b1;
            next_ptr = PTR_BITS'(rr_index(int'(ptr), k + 1, NUM_REQ));
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hub75_mem_scheduler.sv
// rtl/hub75_mem_scheduler.sv - round-robin write-port scheduler with optional frame fill
// Purpose: shares the driver's single frame-memory write port between NUM_REQ
//          valid/ready requesters; optional fill engine (macro
//          HUB75_MEM_SCHEDULER_FILL_EN) paints every address one colour and
//          has absolute priority over requesters while running.
// Ports:
//   reset              in  1                    synchronous active-high reset
//   clk                in  1                    system clock (also driver mem_clk)
//   s_valid / s_ready  in/out NUM_REQ           per-requester handshake
//   s_addr             in  NUM_REQ*ADDR_BITS    requester i uses slice i
//   s_r, s_g, s_b      in  NUM_REQ*DATA_BITS    requester colour, slice i
//   fill_start         in  1                    fill request pulse
//   fill_r/g/b         in  DATA_BITS            fill colour, sampled on accept
//   fill_busy          out 1                    fill in progress
//   fill_done          out 1                    pulse alongside the last fill write
//   grant              out NUM_REQ              source of current m_we (0 for fill)
//   m_we, m_addr       out 1, ADDR_BITS         memory write port
//   m_r, m_g, m_b      out DATA_BITS            memory write data
module hub75_mem_scheduler
   import hub75_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int N         = HUB75_N,
   parameter int WIDTH     = HUB75_WIDTH,
   parameter int HEIGHT    = HUB75_HEIGHT,
   parameter int DATA_BITS = HUB75_DATA_BITS,
   parameter int DEPTH     = N * HEIGHT * WIDTH,
   parameter int ADDR_BITS = $clog2(DEPTH)
) (
   input  logic                           reset,
   input  logic                           clk,
   input  logic [NUM_REQ-1:0]             s_valid,
   output logic [NUM_REQ-1:0]             s_ready,
   input  logic [NUM_REQ*ADDR_BITS-1:0]   s_addr,
   input  logic [NUM_REQ*DATA_BITS-1:0]   s_r,
   input  logic [NUM_REQ*DATA_BITS-1:0]   s_g,
   input  logic [NUM_REQ*DATA_BITS-1:0]   s_b,
   input  logic                           fill_start,
   input  logic [DATA_BITS-1:0]           fill_r,
   input  logic [DATA_BITS-1:0]           fill_g,
   input  logic [DATA_BITS-1:0]           fill_b,
   output logic                           fill_busy,
   output logic                           fill_done,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           m_we,
   output logic [ADDR_BITS-1:0]           m_addr,
   output logic [DATA_BITS-1:0]           m_r,
   output logic [DATA_BITS-1:0]           m_g,
   output logic [DATA_BITS-1:0]           m_b
);

   localparam int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Output register stage
   logic                 m_we_q, m_we_d;
   logic [ADDR_BITS-1:0] m_addr_q, m_addr_d;
   logic [DATA_BITS-1:0] m_r_q, m_r_d, m_g_q, m_g_d, m_b_q, m_b_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [PTR_BITS-1:0]  ptr_q, ptr_d;

   // Arbiter and fill-engine interface
   logic [NUM_REQ-1:0]   arb_grant;
   logic [PTR_BITS-1:0]  arb_next_ptr;
   logic                 arb_en;
   logic                 fill_step;
   logic [ADDR_BITS-1:0] fill_addr;
   logic [DATA_BITS-1:0] fill_pix_r, fill_pix_g, fill_pix_b;

   // Selected requester payload
   logic [ADDR_BITS-1:0] sel_addr;
   logic [DATA_BITS-1:0] sel_r, sel_g, sel_b;

   hub75_rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .PTR_BITS (PTR_BITS)
   ) u_arb (
      .valid    (s_valid),
      .en       (arb_en),
      .ptr      (ptr_q),
      .grant    (arb_grant),
      .next_ptr (arb_next_ptr)
   );

   assign s_ready = arb_grant;

`ifdef HUB75_MEM_SCHEDULER_FILL_EN
   hub75_fill_state_t    fill_state_q, fill_state_d;
   logic [ADDR_BITS-1:0] fill_cnt_q, fill_cnt_d;
   logic [DATA_BITS-1:0] fill_r_q, fill_r_d, fill_g_q, fill_g_d, fill_b_q, fill_b_d;
   logic                 fill_busy_q, fill_busy_d, fill_done_q, fill_done_d;
   logic                 fill_accept;

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

   // fill_busy stays high one cycle past the FILL state so it covers the
   // presentation of the last write; a start in that cycle is ignored too.
   always_comb begin
      fill_accept  = (fill_state_q == IDLE) && fill_start && !fill_busy_q;
      fill_state_d = fill_state_q;
      fill_cnt_d   = fill_cnt_q;
      fill_r_d     = fill_r_q;
      fill_g_d     = fill_g_q;
      fill_b_d     = fill_b_q;
      fill_busy_d  = 1'b0;
      fill_done_d  = 1'b0;
      if (fill_state_q == IDLE) begin
         if (fill_accept) begin
            fill_state_d = FILL;
            fill_cnt_d   = '0;
            fill_r_d     = fill_r;
            fill_g_d     = fill_g;
            fill_b_d     = fill_b;
            fill_busy_d  = 1'b1;
         end
      end else begin
         fill_busy_d = 1'b1;
         fill_cnt_d  = fill_cnt_q + 1'b1;
         if (fill_cnt_q == LAST_ADDR) begin
            fill_state_d = IDLE;
            fill_done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill_state_q <= IDLE;
         fill_cnt_q   <= '0;
         fill_r_q     <= '0;
         fill_g_q     <= '0;
         fill_b_q     <= '0;
         fill_busy_q  <= 1'b0;
         fill_done_q  <= 1'b0;
      end else begin
         fill_state_q <= fill_state_d;
         fill_cnt_q   <= fill_cnt_d;
         fill_r_q     <= fill_r_d;
         fill_g_q     <= fill_g_d;
         fill_b_q     <= fill_b_d;
         fill_busy_q  <= fill_busy_d;
         fill_done_q  <= fill_done_d;
      end
   end

   assign fill_step  = (fill_state_q == FILL);
   assign fill_addr  = fill_cnt_q;
   assign fill_pix_r = fill_r_q;
   assign fill_pix_g = fill_g_q;
   assign fill_pix_b = fill_b_q;
   // Requesters are blocked already in the cycle the start is accepted.
   assign arb_en     = !(fill_busy_q || fill_accept);
   assign fill_busy  = fill_busy_q;
   assign fill_done  = fill_done_q;
`else
   logic unused_fill_inputs;
   assign unused_fill_inputs = ^{fill_start, fill_r, fill_g, fill_b};

   assign fill_step  = 1'b0;
   assign fill_addr  = '0;
   assign fill_pix_r = '0;
   assign fill_pix_g = '0;
   assign fill_pix_b = '0;
   assign arb_en     = 1'b1;
   assign fill_busy  = 1'b0;
   assign fill_done  = 1'b0;
`endif

   always_comb begin
      sel_addr = '0;
      sel_r    = '0;
      sel_g    = '0;
      sel_b    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_addr = s_addr[i*ADDR_BITS +: ADDR_BITS];
            sel_r    = s_r[i*DATA_BITS +: DATA_BITS];
            sel_g    = s_g[i*DATA_BITS +: DATA_BITS];
            sel_b    = s_b[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   // Address/data hold their last value on idle cycles.
   always_comb begin
      m_we_d   = 1'b0;
      m_addr_d = m_addr_q;
      m_r_d    = m_r_q;
      m_g_d    = m_g_q;
      m_b_d    = m_b_q;
      grant_d  = arb_grant;
      ptr_d    = arb_next_ptr;
      if (fill_step) begin
         m_we_d   = 1'b1;
         m_addr_d = fill_addr;
         m_r_d    = fill_pix_r;
         m_g_d    = fill_pix_g;
         m_b_d    = fill_pix_b;
      end else if (|arb_grant) begin
         m_we_d   = 1'b1;
         m_addr_d = sel_addr;
         m_r_d    = sel_r;
         m_g_d    = sel_g;
         m_b_d    = sel_b;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_we_q   <= 1'b0;
         m_addr_q <= '0;
         m_r_q    <= '0;
         m_g_q    <= '0;
         m_b_q    <= '0;
         grant_q  <= '0;
         ptr_q    <= '0;
      end else begin
         m_we_q   <= m_we_d;
         m_addr_q <= m_addr_d;
         m_r_q    <= m_r_d;
         m_g_q    <= m_g_d;
         m_b_q    <= m_b_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
      end
   end

   assign m_we   = m_we_q;
   assign m_addr = m_addr_q;
   assign m_r    = m_r_q;
   assign m_g    = m_g_q;
   assign m_b    = m_b_q;
   assign grant  = grant_q;

endmodule

// File: tb/tb_hub75_mem_scheduler.sv
// tb/tb_hub75_mem_scheduler.sv - self-checking bench for hub75_mem_scheduler
module tb_hub75_mem_scheduler;

   localparam int NUM_REQ   = 2;
   localparam int DATA_BITS = 8;
   localparam int DEPTH     = 2 * 32 * 64;
   localparam int ADDR_BITS = 12;
`ifdef HUB75_MEM_SCHEDULER_FILL_EN
   localparam bit FILL_EN = 1'b1;
`else
   localparam bit FILL_EN = 1'b0;
`endif

   logic                         clk = 1'b0;
   logic                         reset;
   logic [NUM_REQ-1:0]           s_valid;
   logic [NUM_REQ-1:0]           s_ready;
   logic [NUM_REQ*ADDR_BITS-1:0] s_addr;
   logic [NUM_REQ*DATA_BITS-1:0] s_r, s_g, s_b;
   logic                         fill_start;
   logic [DATA_BITS-1:0]         fill_r, fill_g, fill_b;
   logic                         fill_busy, fill_done;
   logic [NUM_REQ-1:0]           grant;
   logic                         m_we;
   logic [ADDR_BITS-1:0]         m_addr;
   logic [DATA_BITS-1:0]         m_r, m_g, m_b;

   hub75_mem_scheduler dut (
      .reset      (reset),
      .clk        (clk),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_addr     (s_addr),
      .s_r        (s_r),
      .s_g        (s_g),
      .s_b        (s_b),
      .fill_start (fill_start),
      .fill_r     (fill_r),
      .fill_g     (fill_g),
      .fill_b     (fill_b),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done),
      .grant      (grant),
      .m_we       (m_we),
      .m_addr     (m_addr),
      .m_r        (m_r),
      .m_g        (m_g),
      .m_b        (m_b)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: a fill started in cycle fs writes address (c - fs - 2)
   // in cycle c for c in [fs+2, fs+DEPTH+1]; busy spans [fs+1, fs+DEPTH+1].
   longint               cyc = 0;
   longint               fs  = 0;
   bit                   fs_v = 1'b0;
   int                   ptr_m = 0;
   logic [DATA_BITS-1:0] fr = '0, fg = '0, fb = '0;
   logic                 e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0;
   logic [ADDR_BITS-1:0] e_addr = '0;
   logic [DATA_BITS-1:0] e_r = '0, e_g = '0, e_b = '0;
   logic [NUM_REQ-1:0]   e_grant = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      bit                 busy_now, start_acc;
      int                 win;
      logic [NUM_REQ-1:0] exp_ready;
      busy_now  = FILL_EN && fs_v && (cyc >= fs + 1) && (cyc <= fs + DEPTH + 1);
      start_acc = FILL_EN && !reset && fill_start && !busy_now;
      win = -1;
      if (!(busy_now || start_acc)) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (win < 0 && s_valid[(ptr_m + k) % NUM_REQ]) win = (ptr_m + k) % NUM_REQ;
         end
      end
      exp_ready = (win >= 0) ? NUM_REQ'(1 << win) : '0;
      #1;
      if (!reset) chk("s_ready", 32'(s_ready), 32'(exp_ready));

      if (reset) begin
         e_we = 1'b0; e_addr = '0; e_r = '0; e_g = '0; e_b = '0;
         e_grant = '0; e_busy = 1'b0; e_done = 1'b0;
         ptr_m = 0; fs_v = 1'b0;
      end else begin
         if (start_acc) begin
            fs = cyc; fs_v = 1'b1; fr = fill_r; fg = fill_g; fb = fill_b;
         end
         if (fs_v && (cyc + 1 >= fs + 2) && (cyc + 1 <= fs + DEPTH + 1)) begin
            e_we = 1'b1; e_addr = ADDR_BITS'(cyc + 1 - fs - 2);
            e_r = fr; e_g = fg; e_b = fb; e_grant = '0;
         end else if (win >= 0) begin
            e_we = 1'b1;
            e_addr = s_addr[win*ADDR_BITS +: ADDR_BITS];
            e_r = s_r[win*DATA_BITS +: DATA_BITS];
            e_g = s_g[win*DATA_BITS +: DATA_BITS];
            e_b = s_b[win*DATA_BITS +: DATA_BITS];
            e_grant = NUM_REQ'(1 << win);
            ptr_m = (win + 1) % NUM_REQ;
         end else begin
            e_we = 1'b0; e_grant = '0;
         end
         e_busy = fs_v && (cyc + 1 >= fs + 1) && (cyc + 1 <= fs + DEPTH + 1);
         e_done = fs_v && (cyc + 1 == fs + DEPTH + 1);
      end

      @(posedge clk);
      #1;
      cyc++;
      chk("m_we",      32'(m_we),      32'(e_we));
      chk("m_addr",    32'(m_addr),    32'(e_addr));
      chk("m_rgb",     {8'h0, m_r, m_g, m_b}, {8'h0, e_r, e_g, e_b});
      chk("grant",     32'(grant),     32'(e_grant));
      chk("fill_busy", 32'(fill_busy), 32'(e_busy));
      chk("fill_done", 32'(fill_done), 32'(e_done));
   endtask

   task automatic randomize_requests();
      s_valid = NUM_REQ'($urandom);
      s_addr  = (NUM_REQ*ADDR_BITS)'({$urandom, $urandom});
      s_r     = (NUM_REQ*DATA_BITS)'($urandom);
      s_g     = (NUM_REQ*DATA_BITS)'($urandom);
      s_b     = (NUM_REQ*DATA_BITS)'($urandom);
   endtask

   initial begin
      reset = 1'b1; s_valid = '0; s_addr = '0; s_r = '0; s_g = '0; s_b = '0;
      fill_start = 1'b0; fill_r = '0; fill_g = '0; fill_b = '0;
      #2;

      // Reset state
      step(); step();
      reset = 1'b0;

      // Single requester 0: addr 5, colour (1,2,3)
      s_valid = 2'b01;
      s_addr  = {12'd0, 12'd5};
      s_r = {8'd0, 8'd1}; s_g = {8'd0, 8'd2}; s_b = {8'd0, 8'd3};
      step();
      s_valid = '0;
      step();

      // Round robin from reset: both requesters valid for 4 cycles
      reset = 1'b1; step(); reset = 1'b0;
      s_valid = 2'b11;
      s_addr  = {12'd200, 12'd100};
      for (int i = 0; i < 4; i++) step();
      s_valid = '0;
      step();

      // Randomized requester traffic
      for (int i = 0; i < 300; i++) begin
         randomize_requests();
         step();
      end
      s_valid = '0;
      step();

`ifdef HUB75_MEM_SCHEDULER_FILL_EN
      // Full fill with colour (FF,00,80), random requests alongside, and a
      // restart attempt mid-fill that must be ignored
      fill_start = 1'b1; fill_r = 8'hFF; fill_g = 8'h00; fill_b = 8'h80;
      randomize_requests();
      step();
      fill_start = 1'b0; fill_r = 8'h11; fill_g = 8'h22; fill_b = 8'h33;
      for (int i = 0; i < DEPTH + 6; i++) begin
         randomize_requests();
         fill_start = (i == 10 || i == 2000);
         step();
      end
      fill_start = 1'b0;

      // Start collision with s_valid = 10
      s_valid = 2'b10;
      fill_start = 1'b1; fill_r = 8'h0A; fill_g = 8'h0B; fill_b = 8'h0C;
      step();
      fill_start = 1'b0;
      for (int i = 0; i < DEPTH + 4; i++) step();
      s_valid = '0;
      step();

      // Reset while address 100 is presented, then a fresh fill from 0
      fill_start = 1'b1; fill_r = 8'h55; fill_g = 8'h66; fill_b = 8'h77;
      step();
      fill_start = 1'b0;
      for (int i = 0; i < 101; i++) step();
      chk("abort_point_addr", 32'(m_addr), 32'd100);
      reset = 1'b1;
      step();
      reset = 1'b0;
      fill_start = 1'b1; fill_r = 8'h01; fill_g = 8'h02; fill_b = 8'h03;
      step();
      fill_start = 1'b0;
      for (int i = 0; i < DEPTH + 3; i++) step();
`else
      // Fill logic absent: fill_start is ignored and requester 0 proceeds
      fill_start = 1'b1; fill_r = 8'hFF; fill_g = 8'hFF; fill_b = 8'hFF;
      s_valid = 2'b01;
      s_addr  = {12'd0, 12'd77};
      step();
      fill_start = 1'b0; s_valid = '0;
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 20; i++) begin
         randomize_requests();
         fill_start = 1'(i % 3 == 0);
         step();
      end
      fill_start = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
